// File: rtl/desired_drive_seq.sv
`default_nettype none
// ============================================================================
// Module   : desired_drive_seq
// Purpose  : Computes the motor target current from pedal torque, cadence,
//            incline and assist setting. One 15x15 unsigned multiplier is
//            shared across three steps of a fixed 5-cycle pass. The result
//            is slew-limited before it drives target_curr.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            start            - request one pass (accepted only when idle)
//            en               - assist enable (low drives the update to 0)
//            avg_torque[11:0] - unsigned averaged torque
//            cadence_vec[4:0] - unsigned cadence measure
//            incline[12:0]    - signed incline
//            setting[1:0]     - assist level 0..3
//            busy             - pass in progress
//            vld              - one-cycle pulse after target_curr updates
//            target_curr[11:0]- slew-limited target current
// Revision : 1.0 - initial release
// ============================================================================
module desired_drive_seq #(
  parameter logic [11:0] SLEW_STEP  = 12'h080,
  parameter logic [11:0] TORQUE_MIN = 12'h380
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        en,
  input  logic [11:0] avg_torque,
  input  logic [4:0]  cadence_vec,
  input  logic [12:0] incline,
  input  logic [1:0]  setting,
  output logic        busy,
  output logic        vld,
  output logic [11:0] target_curr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL_A = 3'd1;
  localparam logic [2:0] S_MUL_B = 3'd2;
  localparam logic [2:0] S_MUL_P = 3'd3;
  localparam logic [2:0] S_UPD   = 3'd4;

  logic [2:0]  state_q, state_d;

  // Captured copies of the inputs; the whole pass works from these.
  logic [11:0] torque_q;
  logic [4:0]  cad_q;
  logic [12:0] incl_q;
  logic [1:0]  set_q;
  logic        en_q;

  logic [13:0] a1_q;
  logic [14:0] a2_q;
  logic [28:0] prod_q;
  logic [11:0] target_q, target_d;
  logic        vld_q;

  // --------------------------------------------------------------------------
  // Operand conditioning
  // --------------------------------------------------------------------------
  logic [11:0]        torque_pos;
  logic signed [13:0] incl_sum;
  logic [8:0]         incline_lim;
  logic [5:0]         cadence_factor;

  assign torque_pos = (torque_q > TORQUE_MIN) ? (torque_q - TORQUE_MIN) : 12'd0;

  // Sign-extend to 14 bits so the +256 offset can never wrap.
  assign incl_sum = $signed({incl_q[12], incl_q}) + 14'sd256;

  always_comb begin
    incline_lim = incl_sum[8:0];
    if (incl_sum[13]) begin
      incline_lim = 9'd0;
    end else if (incl_sum > 14'sd511) begin
      incline_lim = 9'd511;
    end
  end

  assign cadence_factor = (cad_q <= 5'd1) ? 6'd0 : ({1'b0, cad_q} + 6'd32);

  // --------------------------------------------------------------------------
  // Shared multiplier: operands steered by the current state
  // --------------------------------------------------------------------------
  logic [14:0] mul_x, mul_y;
  logic [29:0] mul_p;

  always_comb begin
    mul_x = 15'd0;
    mul_y = 15'd0;
    case (state_q)
      S_MUL_A: begin
        mul_x = {3'd0, torque_pos};
        mul_y = {13'd0, set_q};
      end
      S_MUL_B: begin
        mul_x = {6'd0, incline_lim};
        mul_y = {9'd0, cadence_factor};
      end
      S_MUL_P: begin
        mul_x = {1'b0, a1_q};
        mul_y = a2_q;
      end
      default: ;
    endcase
  end

  assign mul_p = {15'd0, mul_x} * {15'd0, mul_y};

  // --------------------------------------------------------------------------
  // Raw target and slew limiter (13-bit compares so nothing wraps)
  // --------------------------------------------------------------------------
  logic [11:0] raw;
  logic [12:0] cur_up;
  logic [12:0] raw_up;

  assign raw    = (|prod_q[28:26]) ? 12'hFFF : prod_q[25:14];
  assign cur_up = {1'b0, target_q} + {1'b0, SLEW_STEP};
  assign raw_up = {1'b0, raw} + {1'b0, SLEW_STEP};

  always_comb begin
    target_d = raw;
    if (!en_q) begin
      target_d = 12'd0;
    end else if ({1'b0, raw} > cur_up) begin
      target_d = cur_up[11:0];
    end else if (raw_up < {1'b0, target_q}) begin
      target_d = target_q - SLEW_STEP;
    end
  end

  // Bits that are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{mul_p[29], prod_q[13:0]};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MUL_A;
      S_MUL_A: state_d = S_MUL_B;
      S_MUL_B: state_d = S_MUL_P;
      S_MUL_P: state_d = S_UPD;
      S_UPD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      torque_q <= 12'd0;
      cad_q    <= 5'd0;
      incl_q   <= 13'd0;
      set_q    <= 2'd0;
      en_q     <= 1'b0;
      a1_q     <= 14'd0;
      a2_q     <= 15'd0;
      prod_q   <= 29'd0;
      target_q <= 12'd0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= (state_q == S_UPD);
      if ((state_q == S_IDLE) && start) begin
        torque_q <= avg_torque;
        cad_q    <= cadence_vec;
        incl_q   <= incline;
        set_q    <= setting;
        en_q     <= en;
      end
      if (state_q == S_MUL_A) a1_q     <= mul_p[13:0];
      if (state_q == S_MUL_B) a2_q     <= mul_p[14:0];
      if (state_q == S_MUL_P) prod_q   <= mul_p[28:0];
      if (state_q == S_UPD)   target_q <= target_d;
    end
  end

  assign vld         = vld_q;
  assign target_curr = target_q;

endmodule
`default_nettype wire

// File: tb/tb_desired_drive_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_desired_drive_seq
// Purpose  : Self-checking bench for desired_drive_seq. Two instances share
//            the stimulus: one with the default slew step, one with a step of
//            12'hFFF. Expected values come from an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_desired_drive_seq;

  localparam logic [11:0] STEP  = 12'h080;
  localparam logic [11:0] STEP2 = 12'hFFF;
  localparam logic [11:0] TMIN  = 12'h380;

  logic        clk = 1'b0;
  logic        rst_n, start, en;
  logic [11:0] avg_torque;
  logic [4:0]  cadence_vec;
  logic [12:0] incline;
  logic [1:0]  setting;
  logic        busy, vld, busy2, vld2;
  logic [11:0] target_curr, target_curr2;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cur  = 0;
  int exp_cur2 = 0;

  always #5 clk = ~clk;

  desired_drive_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en),
    .avg_torque(avg_torque), .cadence_vec(cadence_vec),
    .incline(incline), .setting(setting),
    .busy(busy), .vld(vld), .target_curr(target_curr)
  );

  desired_drive_seq #(.SLEW_STEP(STEP2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en),
    .avg_torque(avg_torque), .cadence_vec(cadence_vec),
    .incline(incline), .setting(setting),
    .busy(busy2), .vld(vld2), .target_curr(target_curr2)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: target before slew limiting, straight from the arithmetic rules.
  function automatic int model_raw(int t, int c, int i13, int s);
    int     tp, inc, il, cf;
    longint p;
    tp  = (t > int'(TMIN)) ? t - int'(TMIN) : 0;
    inc = (i13 >= 4096) ? i13 - 8192 : i13;
    il  = inc + 256;
    if (il < 0)   il = 0;
    if (il > 511) il = 511;
    cf  = (c <= 1) ? 0 : c + 32;
    p   = longint'(tp * s) * longint'(il * cf);
    if (p >= 64'd67108864) return 4095;
    return int'(p / 16384);
  endfunction

  function automatic int model_slew(int cur, int raw, int e, int step);
    if (e == 0)              return 0;
    if (raw > cur + step)    return cur + step;
    if (raw + step < cur)    return cur - step;
    return raw;
  endfunction

  task automatic set_in(input int t, input int c, input int i13, input int s, input int e);
    avg_torque  = 12'(t);
    cadence_vec = 5'(c);
    incline     = 13'(i13);
    setting     = 2'(s);
    en          = 1'(e);
  endtask

  task automatic scramble();
    set_in($urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // One accepted pass; inputs are scrambled right after capture.
  task automatic do_pass(input string tag);
    int r, n1, n2;
    @(negedge clk);
    r  = model_raw(avg_torque, cadence_vec, incline, setting);
    n1 = model_slew(exp_cur,  r, en, STEP);
    n2 = model_slew(exp_cur2, r, en, STEP2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    check_val({tag, "_busy_k"}, busy, 1);
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk); #1;
      check_val({tag, "_busy_mid"}, busy, 1);
      check_val({tag, "_vld_mid"},  vld,  0);
      check_val({tag, "_hold"},     target_curr, exp_cur);
    end
    @(posedge clk); #1;
    exp_cur  = n1;
    exp_cur2 = n2;
    check_val({tag, "_vld"},     vld, 1);
    check_val({tag, "_busy_end"}, busy, 0);
    check_val({tag, "_target"},  target_curr,  exp_cur);
    check_val({tag, "_target2"}, target_curr2, exp_cur2);
    @(posedge clk); #1;
    check_val({tag, "_vld_off"}, vld, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    int r;
    rst_n = 1'b0;
    start = 1'b0;
    set_in(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy",   busy, 0);
    check_val("rst_vld",    vld, 0);
    check_val("rst_target", target_curr, 0);
    rst_n = 1'b1;

    // Nominal ramp: 0x080 steps up to 0x600, then holds.
    for (int p = 0; p < 13; p++) begin
      set_in(12'h780, 5'h10, 0, 2, 1);
      do_pass("nominal");
    end
    check_val("nominal_final", target_curr, 12'h600);
    check_val("nominal_sat2",  target_curr2, 12'h600);

    // Ramp down via incline at -256.
    for (int p = 0; p < 2; p++) begin
      set_in(12'h780, 5'h10, 13'h1F00, 2, 1);
      do_pass("incl_low");
    end
    check_val("incl_low_final", target_curr, 12'h500);
    for (int p = 0; p < 2; p++) begin
      set_in(12'h780, 5'h10, 0, 2, 1);
      do_pass("reramp1");
    end
    // Ramp down via cadence at 1.
    for (int p = 0; p < 2; p++) begin
      set_in(12'h780, 1, 0, 2, 1);
      do_pass("cad_low");
    end
    check_val("cad_low_final", target_curr, 12'h500);
    for (int p = 0; p < 2; p++) begin
      set_in(12'h780, 5'h10, 0, 2, 1);
      do_pass("reramp2");
    end
    // Disable: straight to zero.
    set_in(12'h780, 5'h10, 0, 2, 0);
    do_pass("en_off");
    check_val("en_off_final", target_curr, 0);

    // Saturation.
    set_in(12'hFFF, 31, 13'h0FFF, 3, 1);
    do_pass("sat");
    check_val("sat_final2", target_curr2, 12'hFFF);

    // Busy handling: extra starts at k+2 and k+4 are ignored.
    set_in(12'h900, 20, 100, 1, 1);
    r = model_raw(12'h900, 20, 100, 1);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;                    // k
    @(posedge clk); #1; start = 1'b1;                    // k+1
    @(posedge clk); #1; start = 1'b0;                    // k+2
    check_val("bsy_k2_busy", busy, 1);
    @(posedge clk); #1; start = 1'b1;                    // k+3
    @(posedge clk); #1; start = 1'b0;                    // k+4
    exp_cur  = model_slew(exp_cur,  r, 1, STEP);
    exp_cur2 = model_slew(exp_cur2, r, 1, STEP2);
    check_val("bsy_vld",    vld, 1);
    check_val("bsy_target", target_curr, exp_cur);
    for (int j = 5; j <= 8; j++) begin
      @(posedge clk); #1;
      check_val("bsy_no_queue_vld",  vld, 0);
      check_val("bsy_no_queue_busy", busy, 0);
    end

    // Start held high: vld at k+4, k+9, k+14.
    set_in(12'h600, 9, 13'h1FF0, 3, 1);
    r = model_raw(12'h600, 9, 13'h1FF0, 3);
    @(negedge clk); start = 1'b1;
    @(posedge clk);                                      // k
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (n == 4 || n == 9 || n == 14) begin
        exp_cur  = model_slew(exp_cur,  r, 1, STEP);
        exp_cur2 = model_slew(exp_cur2, r, 1, STEP2);
        check_val("held_vld", vld, 1);
      end else begin
        check_val("held_novld", vld, 0);
      end
      check_val("held_target", target_curr, exp_cur);
    end
    start = 1'b0;
    @(posedge clk); #1;

    // Reset mid-pass.
    set_in(12'hC00, 25, 200, 3, 1);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;                    // k
    @(posedge clk);                                      // k+1
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;                    // k+2
    exp_cur  = 0;
    exp_cur2 = 0;
    check_val("midrst_target", target_curr, 0);
    check_val("midrst_busy",   busy, 0);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      check_val("midrst_novld", vld, 0);
    end
    set_in(12'h780, 5'h10, 0, 2, 1);
    do_pass("after_rst");
    check_val("after_rst_val", target_curr, 12'h080);

    // Randomized passes.
    for (int p = 0; p < 30; p++) begin
      set_in($urandom, $urandom, $urandom, $urandom, ($urandom_range(0, 3) != 0) ? 1 : 0);
      do_pass("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
